// File: rtl/adc_code_averager_if.sv
// Sample-in / result-out bundle for adc_code_averager.
// out_min/out_max exist only when ADC_AVG_MINMAX_EN is defined.
interface adc_code_averager_if #(
  parameter int unsigned B     = 8,
  parameter int unsigned LOG2N = 4
);
  logic [B-1:0]       code;
  logic               code_valid;
  logic [B+LOG2N-1:0] out_sum;
  logic [B-1:0]       out_mean;
  logic               out_valid;
  logic               out_ready;
`ifdef ADC_AVG_MINMAX_EN
  logic [B-1:0]       out_min;
  logic [B-1:0]       out_max;

  modport master (
    output code, code_valid, out_ready,
    input  out_sum, out_mean, out_valid, out_min, out_max
  );
  modport slave (
    input  code, code_valid, out_ready,
    output out_sum, out_mean, out_valid, out_min, out_max
  );
`else
  modport master (
    output code, code_valid, out_ready,
    input  out_sum, out_mean, out_valid
  );
  modport slave (
    input  code, code_valid, out_ready,
    output out_sum, out_mean, out_valid
  );
`endif
endinterface

// File: rtl/adc_code_averager.sv
// Accumulates windows of 2**LOG2N decoder codes into a one-deep sum/mean result slot.
// Optional ADC_AVG_MINMAX_EN adds per-window min/max outputs.
module adc_code_averager #(
  parameter int unsigned B     = 8,
  parameter int unsigned LOG2N = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  adc_code_averager_if.slave  io_bus,
  output logic [15:0]         o_overrun_count,
  output logic                o_busy
);
  localparam int unsigned SW = B + LOG2N;

  typedef enum logic {StIdle, StAccum} state_e;

  state_e           r_state;
  logic [SW-1:0]    r_sum;
  logic [LOG2N-1:0] r_cnt;
  logic [SW-1:0]    r_out_sum;
  logic             r_out_valid;
  logic [15:0]      r_overrun;

  logic [SW-1:0]    w_sum_next;
  logic             w_last;
  logic             w_pop;
  logic             w_slot_free;

  assign w_sum_next  = r_sum + SW'(io_bus.code);
  assign w_last      = (r_cnt == {LOG2N{1'b1}});
  assign w_pop       = r_out_valid && io_bus.out_ready;
  assign w_slot_free = !r_out_valid || w_pop;

`ifdef ADC_AVG_MINMAX_EN
  logic [B-1:0] r_min;
  logic [B-1:0] r_max;
  logic [B-1:0] r_out_min;
  logic [B-1:0] r_out_max;
  logic [B-1:0] w_min_next;
  logic [B-1:0] w_max_next;
  logic         w_first;

  // The first sample of a window re-seeds both trackers.
  assign w_first    = (r_cnt == '0);
  assign w_min_next = (w_first || (io_bus.code < r_min)) ? io_bus.code : r_min;
  assign w_max_next = (w_first || (io_bus.code > r_max)) ? io_bus.code : r_max;

  assign io_bus.out_min = r_out_min;
  assign io_bus.out_max = r_out_max;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= '0;
`ifdef ADC_AVG_MINMAX_EN
      r_min       <= '0;
      r_max       <= '0;
      r_out_min   <= '0;
      r_out_max   <= '0;
`endif
    end else begin
      if (w_pop) r_out_valid <= 1'b0;

      case (r_state)
        StIdle: begin
          if (i_enable) r_state <= StAccum;
        end
        StAccum: begin
          if (!i_enable) begin
            r_state <= StIdle;
            r_sum   <= '0;
            r_cnt   <= '0;
          end else if (io_bus.code_valid) begin
            if (w_last) begin
              r_sum <= '0;
              r_cnt <= '0;
              if (w_slot_free) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum_next;
`ifdef ADC_AVG_MINMAX_EN
                r_out_min   <= w_min_next;
                r_out_max   <= w_max_next;
`endif
              end else if (r_overrun != 16'hFFFF) begin
                r_overrun <= r_overrun + 16'd1;
              end
            end else begin
              r_sum <= w_sum_next;
              r_cnt <= r_cnt + LOG2N'(1);
`ifdef ADC_AVG_MINMAX_EN
              r_min <= w_min_next;
              r_max <= w_max_next;
`endif
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.out_sum   = r_out_sum;
  assign io_bus.out_mean  = r_out_sum[SW-1:LOG2N];
  assign io_bus.out_valid = r_out_valid;
  assign o_overrun_count  = r_overrun;
  assign o_busy           = (r_state == StAccum);

endmodule

// File: tb/tb_adc_code_averager.sv
// Self-checking bench for adc_code_averager (B=8, LOG2N=2): vector table, corner
// sequences and randomized traffic against a window/slot reference model.
module tb_adc_code_averager;
  localparam int unsigned B     = 8;
  localparam int unsigned LOG2N = 2;
  localparam int          N     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] ovr;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc_code_averager_if #(.B(B), .LOG2N(LOG2N)) bus ();

  adc_code_averager #(.B(B), .LOG2N(LOG2N)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .io_bus          (bus),
    .o_overrun_count (ovr),
    .o_busy          (busy)
  );

  // Reference model: samples of the open window, plus the one-entry result slot.
  bit accum_m;
  int win_m[$];
  bit sv_m;
  int sum_m, min_m, max_m, ovr_m;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop;
    int s, mn, mx;
    pop = sv_m && bus.out_ready;
    if (rst) begin
      accum_m = 0; win_m.delete(); sv_m = 0;
      sum_m = 0; min_m = 0; max_m = 0; ovr_m = 0;
      return;
    end
    if (pop) sv_m = 0;
    if (!accum_m) begin
      if (en) accum_m = 1;
    end else if (!en) begin
      accum_m = 0;
      win_m.delete();
    end else if (bus.code_valid) begin
      win_m.push_back(int'(bus.code));
      if (win_m.size() == N) begin
        s = 0; mn = 1 << B; mx = -1;
        foreach (win_m[i]) begin
          s += win_m[i];
          if (win_m[i] < mn) mn = win_m[i];
          if (win_m[i] > mx) mx = win_m[i];
        end
        if (!sv_m) begin
          sv_m = 1; sum_m = s; min_m = mn; max_m = mx;
        end else if (ovr_m < 65535) begin
          ovr_m++;
        end
        win_m.delete();
      end
    end
  endtask

  // Inputs already set; advance one clock and compare against the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_valid", int'(bus.out_valid), int'(sv_m));
    chk("m_sum",   int'(bus.out_sum),   sum_m);
    chk("m_mean",  int'(bus.out_mean),  sum_m / N);
    chk("m_ovr",   int'(ovr),           ovr_m);
    chk("m_busy",  int'(busy),          int'(accum_m));
`ifdef ADC_AVG_MINMAX_EN
    chk("m_min",   int'(bus.out_min),   min_m);
    chk("m_max",   int'(bus.out_max),   max_m);
`endif
  endtask

  task automatic drv(input bit e, input int c, input bit v, input bit r);
    en             = e;
    bus.code       = B'(c);
    bus.code_valid = v;
    bus.out_ready  = r;
    tick();
  endtask

  typedef struct {
    bit en; int code; bit cv; bit rdy;
    bit ev; int esum; int eovr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Windows of 10..40, 255 x4 back-to-back, then 255 x4 with 3-cycle gaps.
    tbl.push_back('{1,   0, 0, 1, 0,    0, 0});
    tbl.push_back('{1,  10, 1, 1, 0,    0, 0});
    tbl.push_back('{1,  20, 1, 1, 0,    0, 0});
    tbl.push_back('{1,  30, 1, 1, 0,    0, 0});
    tbl.push_back('{1,  40, 1, 1, 1,  100, 0});
    tbl.push_back('{1,   0, 0, 1, 0,  100, 0});
    tbl.push_back('{1, 255, 1, 1, 0,  100, 0});
    tbl.push_back('{1, 255, 1, 1, 0,  100, 0});
    tbl.push_back('{1, 255, 1, 1, 0,  100, 0});
    tbl.push_back('{1, 255, 1, 1, 1, 1020, 0});
    tbl.push_back('{1,   0, 0, 1, 0, 1020, 0});
    for (int k = 0; k < 4; k++) begin
      if (k > 0) for (int g = 0; g < 3; g++) tbl.push_back('{1, 0, 0, 1, 0, 1020, 0});
      tbl.push_back('{1, 255, 1, 1, (k == 3), 1020, 0});
    end
    tbl.push_back('{1, 0, 0, 1, 0, 1020, 0});

    rst = 1'b1;
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_sum",   int'(bus.out_sum),   0);
    chk("rst_ovr",   int'(ovr),           0);
    chk("rst_busy",  int'(busy),          0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drv(tbl[i].en, tbl[i].code, tbl[i].cv, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_sum", i),   int'(bus.out_sum),   tbl[i].esum);
      chk($sformatf("tbl%0d_mean", i),  int'(bus.out_mean),  tbl[i].esum >> LOG2N);
      chk($sformatf("tbl%0d_ovr", i),   int'(ovr),           tbl[i].eovr);
    end

    // Three windows of 1s into a stalled slot: first held, two dropped.
    for (int k = 0; k < 12; k++) drv(1, 1, 1, 0);
    chk("ovr3_valid", int'(bus.out_valid), 1);
    chk("ovr3_sum",   int'(bus.out_sum),   4);
    chk("ovr3_cnt",   int'(ovr),           2);
    drv(1, 0, 0, 1);
    chk("ovr3_pop",   int'(bus.out_valid), 0);

    // Pop coinciding with completion of 2,3,4,5.
    for (int k = 0; k < 4; k++) drv(1, 1, 1, 0);
    drv(1, 2, 1, 0);
    drv(1, 3, 1, 0);
    drv(1, 4, 1, 0);
    chk("pp_held", int'(bus.out_sum), 4);
    drv(1, 5, 1, 1);
    chk("pp_valid", int'(bus.out_valid), 1);
    chk("pp_sum",   int'(bus.out_sum),   14);
    chk("pp_ovr",   int'(ovr),           2);
    drv(1, 0, 0, 1);

    // Partial window discarded by a one-cycle enable drop.
    drv(1, 3, 1, 1);
    drv(1, 3, 1, 1);
    drv(0, 3, 1, 1);
    chk("en_busy", int'(busy), 0);
    drv(1, 0, 0, 1);
    for (int k = 0; k < 4; k++) drv(1, 7, 1, 0);
    chk("en_sum",   int'(bus.out_sum),   28);
    chk("en_valid", int'(bus.out_valid), 1);

    // Reset mid-window with a full slot.
    drv(1, 9, 1, 0);
    drv(1, 9, 1, 0);
    rst = 1'b1;
    drv(1, 9, 1, 0);
    rst = 1'b0;
    chk("mr_valid", int'(bus.out_valid), 0);
    chk("mr_sum",   int'(bus.out_sum),   0);
    chk("mr_ovr",   int'(ovr),           0);
    chk("mr_busy",  int'(busy),          0);

    drv(1, 0, 0, 1);
    drv(1, 9, 1, 1);
    drv(1, 3, 1, 1);
    drv(1, 200, 1, 1);
    drv(1, 50, 1, 1);
    chk("mm_sum", int'(bus.out_sum), 262);
`ifdef ADC_AVG_MINMAX_EN
    chk("mm_min", int'(bus.out_min), 3);
    chk("mm_max", int'(bus.out_max), 200);
`endif

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      drv($urandom_range(0, 15) != 0, int'($urandom_range(0, 255)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
